// File: rtl/bcd_serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the digit-serial BCD subtractor.
// The master drives the request; the slave (the subtractor) returns status and result.
interface bcd_serial_subtractor_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   D;
  logic                  Bout;
  logic                  invalid;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, invalid
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: D = A - B - Bin, one digit per clock, LSD first,
// with a rippled borrow. Out-of-range operand digits abort with invalid=1.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              invalid_q, invalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIGITS-1:0] digit_bad;
  logic [3:0]        a_cur, b_cur, d_cur;
  logic signed [4:0] t;
  logic              borrow_cur;

  // Validity is judged on the latched operands, so the check lands in the first RUN cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign digit_bad[gi] = (a_q[4*gi +: 4] > 4'd9) || (b_q[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_comb begin
    a_cur      = a_q[4*idx_q +: 4];
    b_cur      = b_q[4*idx_q +: 4];
    t          = $signed({1'b0, a_cur}) - $signed({1'b0, b_cur}) - $signed({4'b0000, borrow_q});
    borrow_cur = (t < 5'sd0);
    d_cur      = borrow_cur ? 4'(t + 5'sd10) : t[3:0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    borrow_d  = borrow_q;
    idx_d     = idx_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.A;
          b_d       = bus.B;
          borrow_d  = bus.Bin;
          diff_d    = '0;
          bout_d    = 1'b0;
          invalid_d = 1'b0;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (|digit_bad) begin
          invalid_d = 1'b1;
          diff_d    = '0;
          bout_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          diff_d[4*idx_q +: 4] = d_cur;
          borrow_d             = borrow_cur;
          idx_d                = idx_q + IDXW'(1);
          if (idx_q == IDXW'(DIGITS - 1)) begin
            bout_d  = borrow_cur;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      borrow_q  <= 1'b0;
      idx_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      borrow_q  <= borrow_d;
      idx_q     <= idx_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.D       = diff_q;
  assign bus.Bout    = bout_q;
  assign bus.invalid = invalid_q;

endmodule
